// File: rtl/game_pkg.sv
// Shared encodings for the game flow: external 2-bit game state seen by the VGA mux and actors,
// internal sequencer states, and the lives/time field widths.
package game_pkg;

    localparam int LIVES_W = 2;
    localparam int TIME_W  = 10;

    localparam logic [1:0] GAME_INITIAL = 2'b00;
    localparam logic [1:0] GAME_RUNNING = 2'b01;
    localparam logic [1:0] GAME_OVER    = 2'b10;
    localparam logic [1:0] GAME_SUCCESS = 2'b11;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_RUN   = 3'd1,
        S_DYING = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } seq_state_t;

    // The death freeze is still "running" from the display's point of view.
    function automatic logic [1:0] game_state_enc(input seq_state_t s);
        case (s)
            S_RUN, S_DYING: return GAME_RUNNING;
            S_OVER:         return GAME_OVER;
            S_WIN:          return GAME_SUCCESS;
            default:        return GAME_INITIAL;
        endcase
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Game-flow bundle: player/world inputs into the sequencer and the flow state it publishes.
// master = sequencer side, slave = keyboard/collision logic and state consumers.
interface game_sequencer_if;
    import game_pkg::*;

    logic               tick;
    logic               key_start;
    logic               hit;
    logic               goal;
    logic [1:0]         state;
    logic               actor_rst;
    logic               freeze;
    logic [LIVES_W-1:0] lives;
    logic [TIME_W-1:0]  time_left;

    modport master (
        input  tick, key_start, hit, goal,
        output state, actor_rst, freeze, lives, time_left
    );

    modport slave (
        output tick, key_start, hit, goal,
        input  state, actor_rst, freeze, lives, time_left
    );
endinterface

// File: rtl/game_sequencer_edge_pulse.sv
// Rising-edge detector: one-clk pulse in the same clk the input first reads high, no backpressure.
// RST_VAL=1 makes a level already high at reset release look old, so it never fires.
module edge_pulse #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);
    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= RST_VAL;
        else        d_q <= d;
    end

    assign pulse = d & ~d_q;
endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: INIT -> RUN -> (DYING) -> OVER/WIN, plus lives and countdown timer.
// All outputs registered, one clk after the deciding input; no backpressure, inputs sampled every clk.
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES         = 3,
    parameter int TIME_LIMIT    = 300,
    parameter int TICKS_PER_SEC = 48,
    parameter int DEATH_TICKS   = 96
) (
    input  logic clk,
    input  logic rst,
    game_sequencer_if.master gs
);
    localparam int SUB_W = $clog2(TICKS_PER_SEC + 1);
    localparam int DTH_W = $clog2(DEATH_TICKS + 1);

    seq_state_t         st_q, st_d;
    logic [SUB_W-1:0]   sub_q;
    logic [DTH_W-1:0]   dth_q;
    logic [LIVES_W-1:0] lives_q;
    logic [TIME_W-1:0]  time_q;
    logic [1:0]         state_q;
    logic               actor_rst_q;
    logic               freeze_q;
    logic               start_pulse;
    logic               sec_wrap;
    logic               death_done;
    logic               respawn;

    edge_pulse #(.RST_VAL(1'b1)) u_start_edge (
        .clk   (clk),
        .rst_n (rst),
        .d     (gs.key_start),
        .pulse (start_pulse)
    );

    assign sec_wrap   = gs.tick && (sub_q == SUB_W'(TICKS_PER_SEC - 1));
    assign death_done = gs.tick && (dth_q == DTH_W'(DEATH_TICKS - 1));

    always_comb begin
        st_d    = st_q;
        respawn = 1'b0;
        case (st_q)
            S_INIT: if (start_pulse) st_d = S_RUN;
            S_RUN: begin
                // goal wins over a simultaneous hit; timeout is the weakest exit
                if (gs.goal)                          st_d = S_WIN;
                else if (gs.hit || time_q == '0)      st_d = S_DYING;
            end
            S_DYING: begin
                if (death_done) begin
                    if (lives_q <= LIVES_W'(1)) begin
                        st_d = S_OVER;
                    end else begin
                        st_d    = S_RUN;
                        respawn = 1'b1;
                    end
                end
            end
            S_OVER, S_WIN: if (start_pulse) st_d = S_INIT;
            default: st_d = S_INIT;
        endcase
    end

    // Outputs follow the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= S_INIT;
            state_q     <= GAME_INITIAL;
            actor_rst_q <= 1'b1;
            freeze_q    <= 1'b0;
        end else begin
            st_q        <= st_d;
            state_q     <= game_state_enc(st_d);
            actor_rst_q <= (st_d == S_INIT) || respawn;
            freeze_q    <= (st_d == S_DYING);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lives_q <= LIVES_W'(LIVES);
            time_q  <= TIME_W'(TIME_LIMIT);
            sub_q   <= '0;
            dth_q   <= '0;
        end else begin
            case (st_q)
                S_INIT: begin
                    if (start_pulse) begin
                        lives_q <= LIVES_W'(LIVES);
                        time_q  <= TIME_W'(TIME_LIMIT);
                        sub_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (st_d == S_DYING) begin
                        dth_q <= '0;
                    end else if (st_d == S_RUN && gs.tick) begin
                        if (sec_wrap) begin
                            sub_q <= '0;
                            if (time_q != '0) time_q <= time_q - 1'b1;
                        end else begin
                            sub_q <= sub_q + 1'b1;
                        end
                    end
                end
                S_DYING: begin
                    if (death_done) begin
                        lives_q <= lives_q - 1'b1;
                        if (respawn) begin
                            time_q <= TIME_W'(TIME_LIMIT);
                            sub_q  <= '0;
                        end
                    end else if (gs.tick) begin
                        dth_q <= dth_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gs.state     = state_q;
    assign gs.actor_rst = actor_rst_q;
    assign gs.freeze    = freeze_q;
    assign gs.lives     = lives_q;
    assign gs.time_left = time_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with LIVES=2, TIME_LIMIT=3, TICKS_PER_SEC=4, DEATH_TICKS=2.
module tb_game_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    game_sequencer_if gif();

    game_sequencer #(
        .LIVES         (2),
        .TIME_LIMIT    (3),
        .TICKS_PER_SEC (4),
        .DEATH_TICKS   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .gs  (gif.master)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            gif.tick = 1'b1;
            step(1);
            gif.tick = 1'b0;
            step(1);
        end
    endtask

    task automatic press_start();
        gif.key_start = 1'b0;
        step(1);
        gif.key_start = 1'b1;
        step(1);
    endtask

    task automatic pulse_hit();
        gif.hit = 1'b1;
        step(1);
        gif.hit = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int st, input int ar, input int fr,
                              input int lv, input int tl);
        check_val({tag, ".state"},     gif.state,     st);
        check_val({tag, ".actor_rst"}, gif.actor_rst, ar);
        check_val({tag, ".freeze"},    gif.freeze,    fr);
        check_val({tag, ".lives"},     gif.lives,     lv);
        check_val({tag, ".time_left"}, gif.time_left, tl);
    endtask

    initial begin
        gif.tick = 1'b0; gif.hit = 1'b0; gif.goal = 1'b0;
        gif.key_start = 1'b1;           // held through reset
        step(3);
        check_outs("reset", 0, 1, 0, 2, 3);
        rst = 1'b1;
        step(3);
        check_val("held_key_no_start", gif.state, 0);
        check_val("held_key_actor_rst", gif.actor_rst, 1);

        // Game A: hit death then final hit
        press_start();
        check_outs("start_a", 1, 0, 0, 2, 3);
        pulse_hit();
        check_outs("hit1_freeze", 1, 0, 1, 2, 3);
        tick_n(1);
        check_val("hit1_lives_hold", gif.lives, 2);
        gif.tick = 1'b1;
        step(1);
        gif.tick = 1'b0;
        check_outs("hit1_respawn", 1, 1, 0, 1, 3);
        step(1);
        check_val("hit1_actor_rst_drop", gif.actor_rst, 0);
        pulse_hit();
        check_val("hit2_freeze", gif.freeze, 1);
        tick_n(1);
        gif.tick = 1'b1;
        step(1);
        gif.tick = 1'b0;
        check_outs("game_over", 2, 0, 0, 0, 3);
        tick_n(4);
        check_val("over_timer_frozen", gif.time_left, 3);
        press_start();
        check_outs("over_restart", 0, 1, 0, 0, 3);

        // Game B: start coincident with a tick, then timeout death
        gif.key_start = 1'b0;
        step(1);
        gif.key_start = 1'b1;
        gif.tick = 1'b1;
        step(1);
        gif.tick = 1'b0;
        check_outs("start_b", 1, 0, 0, 2, 3);
        step(1);
        tick_n(3);
        check_val("start_tick_not_counted", gif.time_left, 3);
        tick_n(1);
        check_val("time_after_4", gif.time_left, 2);
        tick_n(4);
        check_val("time_after_8", gif.time_left, 1);
        tick_n(4);
        check_outs("timeout", 1, 0, 1, 2, 0);
        press_start();
        check_outs("start_in_dying_ignored", 1, 0, 1, 2, 0);
        tick_n(1);
        check_val("timeout_lives_hold", gif.lives, 2);
        gif.tick = 1'b1;
        step(1);
        gif.tick = 1'b0;
        check_outs("timeout_respawn", 1, 1, 0, 1, 3);
        step(1);
        check_val("timeout_actor_rst_drop", gif.actor_rst, 0);
        gif.goal = 1'b1;
        gif.hit  = 1'b1;
        step(1);
        gif.goal = 1'b0;
        gif.hit  = 1'b0;
        check_outs("goal_beats_hit", 3, 0, 0, 1, 3);
        press_start();
        check_outs("win_restart", 0, 1, 0, 1, 3);

        // Game C: asynchronous reset in the middle of the death freeze
        press_start();
        pulse_hit();
        tick_n(1);
        check_val("c_dying", gif.freeze, 1);
        #2;
        rst = 1'b0;
        #1;
        check_outs("async_reset", 0, 1, 0, 2, 3);
        step(2);
        rst = 1'b1;
        step(2);
        check_val("post_reset_held_key", gif.state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game flow controller. It replaces the hard-wired start/over/restart/success ties and drives the state consumed by the VGA mux and the mario/kong/queue/barrel actors. It sequences the INITIAL -> RUNNING -> (DYING) -> OVER/SUCCESS flow from the keyboard start key, the mario–barrel collision and the goal-reached flag. It also owns the lives counter and the countdown timer that the seven-segment display reads.

Parameters:
LIVES, 3, lives at game start (1..3)
TIME_LIMIT, 300, countdown start value in seconds (<=1023)
TICKS_PER_SEC, 48, game ticks per countdown second (clk_div[20] rate ~47.7 Hz at 100 MHz)
DEATH_TICKS, 96, game ticks the death freeze lasts (>=1)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  reset; one clock; reset is asynchronous and active-low
tick  in  1  one-clk pulse per game tick (rising edge of clk_div[20], synchronised outside)
key_start  in  1  start/restart key level from key2state
hit  in  1  mario–barrel overlap, level, valid every clk
goal  in  1  mario has reached queue platform, level
state  out  2  00 INITIAL, 01 RUNNING, 10 OVER, 11 SUCCESS
actor_rst  out  1  high = hold all actors at spawn position
freeze  out  1  high = actors must not advance (death animation)
lives  out  2  remaining lives
time_left  out  10  seconds remaining

Behaviour:
- Internal FSM: S_INIT, S_RUN, S_DYING, S_OVER, S_WIN. The state output maps S_DYING to 01 (RUNNING); all other states map one-to-one.
- Reset (rst=0, async): S_INIT, lives=LIVES, time_left=TIME_LIMIT, sub-second counter=0, death counter=0, actor_rst=1, freeze=0. Every output is registered.
- start_pulse: rising edge of key_start, one clk. Internal edge register resets to 1, so a key held through reset does not start the game.
- S_INIT: actor_rst=1. On start_pulse:
  - go to S_RUN next clk
  - lives<=LIVES, time_left<=TIME_LIMIT, sub counter<=0
  - actor_rst<=0
- S_RUN: freeze=0, actor_rst=0.
  - On tick, the sub counter increments. At TICKS_PER_SEC-1 it wraps to 0 and time_left decrements.
  - time_left saturates at 0 and never wraps.
  - Exit priority, evaluated every clk: goal > hit > timeout (time_left==0).
  - goal -> S_WIN.
  - hit or timeout -> S_DYING, death counter<=0, freeze<=1.
  - When the decrement to 0 lands in the same clk as hit, take the hit path once; lives drop once only.
- S_DYING: freeze=1; hit and goal are ignored.
  - The death counter increments on tick. When it reaches DEATH_TICKS-1 and tick is high, lives decrements.
  - If lives was 1: go to S_OVER (lives=0, freeze<=0).
  - Otherwise: go to S_RUN, time_left<=TIME_LIMIT, sub counter<=0, freeze<=0, and actor_rst pulses high for exactly 1 clk.
- S_OVER / S_WIN: freeze=0, timer frozen, lives held.
  - start_pulse -> S_INIT. actor_rst=1 from the next clk.
  - This path replaces the old restart signal.
- start_pulse is ignored in S_RUN and S_DYING.
- tick and start_pulse in the same clk in S_INIT: the transition happens and the tick is not counted.
- Asserting reset mid-game (any state): immediate return to reset values. There is no partial-state retention.

Decomposition:
- Shared package game_pkg:
  - GAME_INITIAL/RUNNING/OVER/SUCCESS 2-bit encodings, shared with the VGA mux and the actors
  - internal S_* encodings
  - LIVES_W=2, TIME_W=10
- Sub-module edge_pulse: rising-edge detector with async active-low reset and a parameterised reset value. It is used for key_start and is reusable for other keys.
- Everything else lives in game_sequencer: the FSM and both counters.

Test Plan:
Bench settings for all tests: LIVES=2, TIME_LIMIT=3, TICKS_PER_SEC=4, DEATH_TICKS=2.
- Reset then key_start rising edge -> state 00 -> 01 next clk, actor_rst 1 -> 0, lives=2, time_left=3.
- RUN with 12 ticks, no hit/goal -> time_left 3,2,1,0 after ticks 4,8,12. After that: state stays 01, freeze=1, and after 2 more ticks lives=1, time_left=3, actor_rst high for 1 clk.
- RUN, hit high 1 clk -> freeze=1 next clk, lives stays 2 until 2 ticks later, then lives=1. Second hit -> after 2 ticks state=10, lives=0, freeze=0.
- RUN, goal and hit asserted in the same clk -> state=11, lives unchanged, freeze stays 0. Then key_start edge -> state=00, actor_rst=1.
- key_start held high across reset release -> no start. After release then press -> start. start_pulse during S_DYING is ignored.
- rst low mid-S_DYING -> same clk (async): state=00, freeze=0, actor_rst=1, lives=2, time_left=3.
